imem_boot_loader: RTL and testbench
===================================

IMEM_BOOT_LOADER -- requirements
Module: imem_boot_loader

Interface
REQ-001 SHALL have parameter ADDR_BASE, default 32'h0000_0000, giving the byte address of the first instruction word written.
REQ-002 SHALL have parameter MAX_WORDS, default 256, giving the largest legal word count (1..65535).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port rx_valid, input, 1 bit: the byte-stream source presents a byte.
REQ-006 SHALL have port rx_data, input, 8 bits: the stream byte.
REQ-007 SHALL have port rx_ready, output, 1 bit: the loader accepts a byte; a transfer occurs when rx_valid and rx_ready are both 1 on a rising clk edge.
REQ-008 SHALL have port imem_we, output, 1 bit: write strobe to the instruction memory.
REQ-009 SHALL have port imem_addr, output, 32 bits: byte address of the write.
REQ-010 SHALL have port imem_wdata, output, 32 bits: instruction word to write.
REQ-011 SHALL have port core_reset, output, 1 bit: reset to the mips_32 pipeline, held high until the load completes.
REQ-012 SHALL have port done, output, 1 bit: load completed successfully.
REQ-013 SHALL have port err, output, 1 bit: load aborted.

Function
REQ-014 SHALL parse the stream as: 2-byte word count N (MSB first), then N words of 4 bytes each (MSB first), then an optional checksum byte (see Configuration).
REQ-015 SHALL implement the states HDR_HI, HDR_LO, WORD, CSUM, DONE and ERROR; reset enters HDR_HI.
REQ-016 SHALL drive rx_ready to 1 in HDR_HI, HDR_LO, WORD and CSUM, and to 0 in DONE and ERROR.
REQ-017 SHALL hold state and all counters unchanged in any cycle with no transfer; gaps in rx_valid of any length SHALL be tolerated.
REQ-018 SHALL transition from HDR_LO when it accepts the low count byte: to ERROR if N > MAX_WORDS; to CSUM or DONE if N == 0; to WORD otherwise.
REQ-019 SHALL, in WORD, count bytes 0..3 with a 2-bit counter that wraps from 3 to 0; on accepting byte 3 it SHALL pulse imem_we high for exactly the next cycle, with imem_wdata set to the assembled word and imem_addr = ADDR_BASE + 4*k, where k counts words from 0.
REQ-020 SHALL compute imem_addr modulo 2^32, wrapping silently.
REQ-021 SHALL leave WORD after the Nth word's byte 3 is accepted; back-to-back writes SHALL be spaced by at least 4 cycles.
REQ-022 SHALL keep imem_we at 0 in every cycle other than the REQ-019 pulses; imem_addr and imem_wdata SHALL hold their last values between pulses.
REQ-023 SHALL make DONE and ERROR absorbing until reset.
REQ-024 SHALL drive core_reset = 0 only while in DONE.
REQ-025 SHALL drive done = 1 only in DONE and err = 1 only in ERROR; both SHALL be registered.
REQ-026 SHALL change core_reset low in the same cycle that done rises, which is the cycle after the final byte is accepted.

Reset
REQ-027 SHALL, on reset = 1 at a rising clk edge, set rx_ready=0, imem_we=0, imem_addr=ADDR_BASE, imem_wdata=0, core_reset=1, done=0 and err=0, clear the counters and checksum, and enter HDR_HI; rx_ready SHALL go to 1 in the first cycle after reset deasserts.
REQ-028 SHALL, if reset is asserted mid-load, discard the partial word with no imem_we pulse, and the next load SHALL restart at ADDR_BASE.

Configuration
REQ-029 SHALL, with macro BOOT_CHECKSUM_EN defined, require one checksum byte after the last word (or directly after the header when N=0), enter DONE if that byte equals the XOR of all preceding header and data bytes, and enter ERROR otherwise.
REQ-030 SHALL, without BOOT_CHECKSUM_EN, omit the CSUM state and checksum register and go directly to DONE after the last word (or header when N=0).

Verification
REQ-031 SHALL cover: stream 00 02 | 20 08 00 05 | 8C 09 00 04 (+AE if BOOT_CHECKSUM_EN), rx_valid held high -> writes (0x0,0x20080005) and (0x4,0x8C090004), then done=1 and core_reset=0.
REQ-032 SHALL cover: the same stream with checksum byte 0xAF under BOOT_CHECKSUM_EN -> both writes occur, then err=1, done=0, core_reset stays 1 and rx_ready=0.
REQ-033 SHALL cover: header 00 00 (+00 if BOOT_CHECKSUM_EN) -> no imem_we pulse and done=1.
REQ-034 SHALL cover: header 01 01 with MAX_WORDS=256 -> ERROR entered the cycle after the second byte and no writes.
REQ-035 SHALL cover: the REQ-031 stream with rx_valid deasserted for 3 cycles between every byte -> identical writes and the same final state.
REQ-036 SHALL cover: reset pulsed after 2 bytes of word 1, then the full REQ-031 stream -> no spurious write, and the first write goes to 0x0.

Source files
------------

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: loads a count-prefixed byte stream into instruction memory, holding the core in reset until done.
// Optional checksum byte enabled by defining BOOT_CHECKSUM_EN.
module imem_boot_loader #(
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
  parameter int          MAX_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        core_reset,
  output logic        done,
  output logic        err
);
`ifdef BOOT_CHECKSUM_EN
  typedef enum logic [2:0] {HDR_HI, HDR_LO, WORD, CSUM, DONE, ERROR} state_t;
  localparam state_t FIN = CSUM;
  logic [7:0] csum;
`else
  typedef enum logic [2:0] {HDR_HI, HDR_LO, WORD, DONE, ERROR} state_t;
  localparam state_t FIN = DONE;
`endif
  state_t state, state_nx;
  logic [7:0]  n_hi;
  logic [15:0] n_words, k, n_full;
  logic [1:0]  bcnt;
  logic [23:0] sh;
  logic        xfer;
  assign xfer   = rx_valid && rx_ready;
  assign n_full = {n_hi, rx_data};
  always_comb begin
    state_nx = state;
    if (xfer)
      case (state)
        HDR_HI: state_nx = HDR_LO;
        HDR_LO: state_nx = (int'(n_full) > MAX_WORDS) ? ERROR : (n_full == 16'd0) ? FIN : WORD;
        WORD:   state_nx = (bcnt == 2'd3 && k == n_words - 16'd1) ? FIN : WORD;
`ifdef BOOT_CHECKSUM_EN
        CSUM:   state_nx = (rx_data == csum) ? DONE : ERROR;
`endif
        default: state_nx = state;
      endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= HDR_HI;
      rx_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= ADDR_BASE;
      imem_wdata <= 32'd0;
      core_reset <= 1'b1;
      done       <= 1'b0;
      err        <= 1'b0;
      n_hi       <= 8'd0;
      n_words    <= 16'd0;
      k          <= 16'd0;
      bcnt       <= 2'd0;
      sh         <= 24'd0;
`ifdef BOOT_CHECKSUM_EN
      csum       <= 8'd0;
`endif
    end else begin
      state      <= state_nx;
      rx_ready   <= (state_nx != DONE) && (state_nx != ERROR);
      core_reset <= state_nx != DONE;
      done       <= state_nx == DONE;
      err        <= state_nx == ERROR;
      imem_we    <= 1'b0;
      if (xfer) begin
`ifdef BOOT_CHECKSUM_EN
        csum <= csum ^ rx_data;
`endif
        if (state == HDR_HI) n_hi <= rx_data;
        if (state == HDR_LO) n_words <= n_full;
        if (state == WORD) begin
          bcnt <= bcnt + 2'd1;
          sh   <= {sh[15:0], rx_data};
          if (bcnt == 2'd3) begin
            imem_we    <= 1'b1;
            imem_wdata <= {sh, rx_data};
            imem_addr  <= ADDR_BASE + {14'd0, k, 2'b00};
            k          <= k + 16'd1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: scoreboard bench for imem_boot_loader; expected writes queued per stream, popped on imem_we.
module tb_imem_boot_loader;
  logic        clk = 1'b0, reset = 1'b1, rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_ready, imem_we, core_reset, done, err;
  logic [31:0] imem_addr, imem_wdata;
  int          checks = 0, errors = 0, n_writes = 0;
  logic [63:0] exp_q[$];
  logic [63:0] mon_e;
  logic        we_prev = 1'b0;
  logic [7:0]  stream[$];

  imem_boot_loader dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .core_reset(core_reset), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      n_writes++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL spurious_write got addr=%h data=%h, expected no write", imem_addr, imem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        if ({imem_addr, imem_wdata} !== mon_e) begin
          errors++;
          $display("FAIL write got addr=%h data=%h, expected addr=%h data=%h", imem_addr, imem_wdata, mon_e[63:32], mon_e[31:0]);
        end
      end
      checks++;
      if (we_prev !== 1'b0) begin
        errors++;
        $display("FAIL we_width got we high in consecutive cycles, expected single-cycle pulse");
      end
    end
    we_prev = imem_we;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout, expected bench to finish");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    reset = 1'b1;
    rx_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    while (rx_ready !== 1'b1 && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (t == 50) begin
      checks++;
      errors++;
      $display("FAIL rx_ready_timeout got rx_ready=%b, expected 1 within 50 cycles", rx_ready);
    end else begin
      rx_valid = 1'b1;
      rx_data = b;
      @(posedge clk); #1;
    end
  endtask

  task automatic send_stream(input int gap);
    foreach (stream[i]) begin
      send_byte(stream[i]);
      if (gap > 0) begin
        rx_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
      end
    end
    rx_valid = 1'b0;
  endtask

  task automatic build_good(input logic [7:0] cs);
    stream = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h04};
`ifdef BOOT_CHECKSUM_EN
    stream.push_back(cs);
`else
    if (cs == 8'hFF) stream.push_back(cs);
`endif
  endtask

  task automatic check_final(input string tag, input logic e_done, input logic e_err, input int e_writes);
    checks++;
    if (done !== e_done) begin errors++; $display("FAIL %s_done got %b, expected %b", tag, done, e_done); end
    checks++;
    if (err !== e_err) begin errors++; $display("FAIL %s_err got %b, expected %b", tag, err, e_err); end
    checks++;
    if (core_reset !== !e_done) begin errors++; $display("FAIL %s_core_reset got %b, expected %b", tag, core_reset, !e_done); end
    checks++;
    if (rx_ready !== 1'b0) begin errors++; $display("FAIL %s_rx_ready got %b, expected 0", tag, rx_ready); end
    repeat (4) begin @(posedge clk); #1; end
    checks++;
    if (done !== e_done || err !== e_err) begin errors++; $display("FAIL %s_absorb got done=%b err=%b, expected done=%b err=%b", tag, done, err, e_done, e_err); end
    checks++;
    if (n_writes !== e_writes) begin errors++; $display("FAIL %s_writes got %0d, expected %0d", tag, n_writes, e_writes); end
    checks++;
    if (exp_q.size() !== 0) begin errors++; $display("FAIL %s_pending got %0d missing writes, expected 0", tag, exp_q.size()); end
  endtask

  task automatic run_good(input string tag, input int gap);
    do_reset();
    n_writes = 0;
    build_good(8'hAE);
    exp_q.push_back({32'h0000_0000, 32'h2008_0005});
    exp_q.push_back({32'h0000_0004, 32'h8C09_0004});
    send_stream(gap);
    check_final(tag, 1'b1, 1'b0, 2);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rx_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    checks++;
    if ({rx_ready, imem_we, core_reset, done, err} !== 5'b00100) begin
      errors++;
      $display("FAIL reset_flags got ready=%b we=%b core_reset=%b done=%b err=%b, expected 0 0 1 0 0", rx_ready, imem_we, core_reset, done, err);
    end
    checks++;
    if (imem_addr !== 32'h0 || imem_wdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_bus got addr=%h data=%h, expected 0 0", imem_addr, imem_wdata);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (rx_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b, expected 1", rx_ready); end
  endtask

  task automatic test_load();
    run_good("load", 0);
  endtask

  task automatic test_bad_csum();
`ifdef BOOT_CHECKSUM_EN
    do_reset();
    n_writes = 0;
    build_good(8'hAF);
    exp_q.push_back({32'h0000_0000, 32'h2008_0005});
    exp_q.push_back({32'h0000_0004, 32'h8C09_0004});
    send_stream(0);
    check_final("bad_csum", 1'b0, 1'b1, 2);
`endif
  endtask

  task automatic test_empty();
    do_reset();
    n_writes = 0;
    stream = '{8'h00, 8'h00};
`ifdef BOOT_CHECKSUM_EN
    stream.push_back(8'h00);
`endif
    send_stream(0);
    check_final("empty", 1'b1, 1'b0, 0);
  endtask

  task automatic test_oversize();
    do_reset();
    n_writes = 0;
    stream = '{8'h01, 8'h01};
    send_stream(0);
    check_final("oversize", 1'b0, 1'b1, 0);
  endtask

  task automatic test_gaps();
    run_good("gaps", 3);
  endtask

  task automatic test_reset_mid();
    do_reset();
    n_writes = 0;
    stream = '{8'h00, 8'h02, 8'h20, 8'h08};
    send_stream(0);
    run_good("reset_mid", 0);
  endtask

  initial begin
    test_reset();
    test_load();
    test_bad_csum();
    test_empty();
    test_oversize();
    test_gaps();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
